// File: rtl/ps2_mouse_tracker.sv
//------------------------------------------------------------------------------
// Module   : ps2_mouse_tracker
// Function : Converts decoded PS/2 mouse packets into an absolute cursor
//            position clamped to [0,X_MAX] x [0,Y_MAX], with button levels,
//            press/release pulses, an update strobe and a reject strobe.
//            Two-stage pipeline: packet capture, then position/button update.
// Options  : PS2_WHEEL_EN - adds a saturating 8-bit wheel accumulator (oWheel)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_tracker #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int Y_INV  = 1
) (
  input  logic           CLOCK,
  input  logic           RST_n,
  input  logic           iTrig,
  input  logic [31:0]    iData,
  input  logic           iRecenter,
  output logic [X_W-1:0] oPosX,
  output logic [Y_W-1:0] oPosY,
  output logic [2:0]     oBtn,
  output logic [2:0]     oPress,
  output logic [2:0]     oRelease,
  output logic           oValid,
  output logic           oErr
`ifdef PS2_WHEEL_EN
  ,
  output logic signed [7:0] oWheel
`endif
);

  localparam logic [X_W-1:0]        C_X_INIT  = X_W'(X_INIT);
  localparam logic [Y_W-1:0]        C_Y_INIT  = Y_W'(Y_INIT);
  localparam logic [X_W-1:0]        C_X_MAX_U = X_W'(X_MAX);
  localparam logic [Y_W-1:0]        C_Y_MAX_U = Y_W'(Y_MAX);
  localparam logic signed [X_W+1:0] C_X_MAX_S = (X_W+2)'(X_MAX);
  localparam logic signed [Y_W+1:0] C_Y_MAX_S = (Y_W+2)'(Y_MAX);

  // Stage 1: captured packet
  logic       s1_vld_q;
  logic       s1_bad_q;
  logic [8:0] s1_dx_q;
  logic [8:0] s1_dy_q;
  logic [2:0] s1_btn_q;

  // Stage 2: architectural state / registered outputs
  logic [X_W-1:0] posx_q, posx_d;
  logic [Y_W-1:0] posy_q, posy_d;
  logic [2:0]     btn_q;
  logic [2:0]     press_q;
  logic [2:0]     rel_q;
  logic           valid_q;
  logic           err_q;

  logic signed [X_W+1:0] ext_x, sum_x;
  logic signed [Y_W+1:0] ext_y, sum_y;
  logic [X_W-1:0]        clamp_x;
  logic [Y_W-1:0]        clamp_y;
  logic                  s1_good;

  assign s1_good = s1_vld_q & ~s1_bad_q;

  // Capture the packet and decode signed 9-bit motion; overflowed axes are zeroed
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      s1_vld_q <= 1'b0;
      s1_bad_q <= 1'b0;
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      s1_btn_q <= '0;
    end else begin
      s1_vld_q <= iTrig;
      if (iTrig) begin
        s1_bad_q <= ~iData[3];
        s1_dx_q  <= iData[6] ? 9'd0 : {iData[4], iData[15:8]};
        s1_dy_q  <= iData[7] ? 9'd0 : {iData[5], iData[23:16]};
        s1_btn_q <= iData[2:0];
      end
    end
  end

  // Accumulate motion in widened signed arithmetic, clamp, and apply recenter priority
  always_comb begin
    ext_x = {{(X_W-7){s1_dx_q[8]}}, s1_dx_q};
    ext_y = {{(Y_W-7){s1_dy_q[8]}}, s1_dy_q};
    sum_x = $signed({2'b00, posx_q}) + ext_x;
    if (Y_INV != 0) begin
      sum_y = $signed({2'b00, posy_q}) - ext_y;
    end else begin
      sum_y = $signed({2'b00, posy_q}) + ext_y;
    end

    if (sum_x[X_W+1]) begin
      clamp_x = '0;
    end else if (sum_x > C_X_MAX_S) begin
      clamp_x = C_X_MAX_U;
    end else begin
      clamp_x = sum_x[X_W-1:0];
    end

    if (sum_y[Y_W+1]) begin
      clamp_y = '0;
    end else if (sum_y > C_Y_MAX_S) begin
      clamp_y = C_Y_MAX_U;
    end else begin
      clamp_y = sum_y[Y_W-1:0];
    end

    posx_d = posx_q;
    posy_d = posy_q;
    if (iRecenter) begin
      posx_d = C_X_INIT;
      posy_d = C_Y_INIT;
    end else if (s1_good) begin
      posx_d = clamp_x;
      posy_d = clamp_y;
    end
  end

  // Commit position, buttons and one-cycle strobes
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      posx_q  <= C_X_INIT;
      posy_q  <= C_Y_INIT;
      btn_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      valid_q <= s1_good;
      err_q   <= s1_vld_q & s1_bad_q;
      if (s1_good) begin
        btn_q   <= s1_btn_q;
        press_q <= s1_btn_q & ~btn_q;
        rel_q   <= ~s1_btn_q & btn_q;
      end else begin
        press_q <= '0;
        rel_q   <= '0;
      end
    end
  end

  assign oPosX    = posx_q;
  assign oPosY    = posy_q;
  assign oBtn     = btn_q;
  assign oPress   = press_q;
  assign oRelease = rel_q;
  assign oValid   = valid_q;
  assign oErr     = err_q;

`ifdef PS2_WHEEL_EN
  logic [3:0]        s1_z_q;
  logic signed [7:0] wheel_q, wheel_d;
  logic signed [8:0] wsum;
  logic              unused_zhi;

  assign unused_zhi = ^iData[31:28];

  // Capture the 4-bit wheel delta alongside the packet
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      s1_z_q <= '0;
    end else if (iTrig) begin
      s1_z_q <= iData[27:24];
    end
  end

  // Saturating wheel accumulation; recenter clears it
  always_comb begin
    wsum    = {wheel_q[7], wheel_q} + {{5{s1_z_q[3]}}, s1_z_q};
    wheel_d = wheel_q;
    if (iRecenter) begin
      wheel_d = '0;
    end else if (s1_good) begin
      if (wsum[8] != wsum[7]) begin
        wheel_d = wsum[8] ? 8'sh80 : 8'sh7F;
      end else begin
        wheel_d = wsum[7:0];
      end
    end
  end

  // Wheel accumulator register
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      wheel_q <= '0;
    end else begin
      wheel_q <= wheel_d;
    end
  end

  assign oWheel = wheel_q;
`else
  logic unused_z;
  assign unused_z = ^iData[31:24];
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_mouse_tracker
// Function : Self-checking bench for ps2_mouse_tracker: directed vector table,
//            hand-written pipeline sequences, and a randomized run compared
//            against an integer-arithmetic reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_mouse_tracker;

  logic        CLOCK = 1'b0;
  logic        RST_n = 1'b0;
  logic        iTrig = 1'b0;
  logic [31:0] iData = '0;
  logic        iRecenter = 1'b0;
  logic [9:0]  oPosX, oPosY;
  logic [2:0]  oBtn, oPress, oRelease;
  logic        oValid, oErr;
`ifdef PS2_WHEEL_EN
  logic signed [7:0] oWheel;
`endif

  int n_vec = 0;
  int n_bad = 0;

  ps2_mouse_tracker dut (
    .CLOCK    (CLOCK),
    .RST_n    (RST_n),
    .iTrig    (iTrig),
    .iData    (iData),
    .iRecenter(iRecenter),
    .oPosX    (oPosX),
    .oPosY    (oPosY),
    .oBtn     (oBtn),
    .oPress   (oPress),
    .oRelease (oRelease),
    .oValid   (oValid),
    .oErr     (oErr)
`ifdef PS2_WHEEL_EN
    ,
    .oWheel   (oWheel)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [30:0] ex(int x, int y, logic [2:0] b, logic [2:0] pr,
                                     logic [2:0] rl, logic v, logic e);
    return {10'(x), 10'(y), b, pr, rl, v, e};
  endfunction

  task automatic check(input string nm, input logic [30:0] exp);
    logic [30:0] obs;
    obs = {oPosX, oPosY, oBtn, oPress, oRelease, oValid, oErr};
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d btn=%b press=%b rel=%b valid=%b err=%b ; expected x=%0d y=%0d btn=%b press=%b rel=%b valid=%b err=%b",
               nm, obs[30:21], obs[20:11], obs[10:8], obs[7:5], obs[4:2], obs[1], obs[0],
               exp[30:21], exp[20:11], exp[10:8], exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [2:0]  pr;
    logic [2:0]  rl;
    logic        v;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  // Reference model state for the randomized phase
  int       mx, my;
  logic [2:0] mb;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  initial begin
    // Packets applied one at a time from reset (320,240); expected state after each
    tbl.push_back('{32'h00_05_0A_08, 10'd330, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_7F_08, 10'd457, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_7F_08, 10'd584, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_2E_08, 10'd630, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_14_08, 10'd639, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_80_18, 10'd511, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_80_18, 10'd383, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_80_18, 10'd255, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_80_18, 10'd127, 10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_86_18, 10'd5,   10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_EC_18, 10'd0,   10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_00_09, 10'd0,   10'd235, 3'b001, 3'b001, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_00_0B, 10'd0,   10'd235, 3'b011, 3'b010, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_00_0A, 10'd0,   10'd235, 3'b010, 3'b000, 3'b001, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_05_00, 10'd0,   10'd235, 3'b010, 3'b000, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{32'h00_00_7F_48, 10'd0,   10'd235, 3'b000, 3'b000, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{32'h00_7F_00_88, 10'd0,   10'd235, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_FF_00_08, 10'd0,   10'd0,   3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_01_00_28, 10'd0,   10'd255, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'h00_00_00_28, 10'd0,   10'd479, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{32'hFF_00_01_08, 10'd1,   10'd479, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});

    // Reset
    RST_n = 1'b0;
    step();
    step();
    check("reset", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    RST_n = 1'b1;
    step();
    check("post_reset_idle", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));

    // Directed table: one packet, check after 2 edges, then check pulses dropped
    for (int i = 0; i < tbl.size(); i++) begin
      iData = tbl[i].data;
      iTrig = 1'b1;
      step();
      iTrig = 1'b0;
      step();
      check($sformatf("tbl%0d", i), {tbl[i].x, tbl[i].y, tbl[i].btn, tbl[i].pr, tbl[i].rl, tbl[i].v, tbl[i].e});
      step();
      check($sformatf("tbl%0d_pulse_end", i), {tbl[i].x, tbl[i].y, tbl[i].btn, 3'b000, 3'b000, 1'b0, 1'b0});
    end

    // Recenter alone
    iRecenter = 1'b1;
    step();
    iRecenter = 1'b0;
    check("recenter", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));

    // Back-to-back packets of X=+100
    iData = 32'h00_00_64_08;
    iTrig = 1'b1;
    step();
    step();
    check("b2b_1", ex(420, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));
    step();
    check("b2b_2", ex(520, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));
    iTrig = 1'b0;
    step();
    check("b2b_3", ex(620, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));
    step();
    check("b2b_idle", ex(620, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));

    // Same burst with recenter colliding with the third update
    iRecenter = 1'b1;
    step();
    iRecenter = 1'b0;
    iTrig = 1'b1;
    step();
    step();
    check("b2b_rc_1", ex(420, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));
    step();
    check("b2b_rc_2", ex(520, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));
    iTrig = 1'b0;
    iRecenter = 1'b1;
    step();
    iRecenter = 1'b0;
    check("b2b_rc_3", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0));

`ifdef PS2_WHEEL_EN
    // Wheel saturation: 20 packets of Z=+7
    iData = 32'h07_00_00_08;
    iTrig = 1'b1;
    for (int i = 0; i < 20; i++) step();
    iTrig = 1'b0;
    step();
    n_vec++;
    if (oWheel !== 8'sd127) begin
      n_bad++;
      $display("FAIL wheel_sat: got %0d expected 127", oWheel);
    end
    iTrig = 1'b1;
    step();
    iTrig = 1'b0;
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    step();
    n_vec++;
    if (oWheel !== 8'sd0 || oValid !== 1'b0) begin
      n_bad++;
      $display("FAIL wheel_reset: got wheel=%0d valid=%b expected 0/0", oWheel, oValid);
    end
`endif

    // Reset with a packet in flight: lost, no pulse
    iData = 32'h00_00_64_09;
    iTrig = 1'b1;
    step();
    iTrig = 1'b0;
    RST_n = 1'b0;
    step();
    check("rst_mid_a", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    RST_n = 1'b1;
    step();
    check("rst_mid_b", ex(320, 240, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));

    // Randomized run against the reference model
    begin
      logic        pv;
      logic [31:0] pd;
      logic        trig, rc;
      logic [31:0] d;
      logic [2:0]  epr, erl, nb;
      logic        ev, ee;
      int          dx, dy;
      mx = 320; my = 240; mb = 3'b000;
      pv = 1'b0; pd = '0;
      for (int c = 0; c < 400; c++) begin
        trig = ($urandom % 2) == 0;
        rc   = ($urandom % 12) == 0;
        d    = $urandom;
        d[3] = ($urandom % 6) != 0;
        d[6] = ($urandom % 8) == 0;
        d[7] = ($urandom % 8) == 0;
        iTrig = trig;
        iData = d;
        iRecenter = rc;
        step();
        epr = 3'b000; erl = 3'b000; ev = 1'b0; ee = 1'b0;
        if (pv) begin
          if (!pd[3]) begin
            ee = 1'b1;
          end else begin
            dx = pd[6] ? 0 : (pd[4] ? int'(pd[15:8]) - 256 : int'(pd[15:8]));
            dy = pd[7] ? 0 : (pd[5] ? int'(pd[23:16]) - 256 : int'(pd[23:16]));
            nb  = pd[2:0];
            epr = nb & ~mb;
            erl = ~nb & mb;
            mb  = nb;
            ev  = 1'b1;
            if (!rc) begin
              mx = clampi(mx + dx, 639);
              my = clampi(my - dy, 479);
            end
          end
        end
        if (rc) begin
          mx = 320;
          my = 240;
        end
        check($sformatf("rand%0d", c), ex(mx, my, mb, epr, erl, ev, ee));
        pv = trig;
        pd = d;
      end
      iTrig = 1'b0;
      iRecenter = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
